hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage DLX integer pipeline.
- Combines three ID-stage hazard requests into per-stage write-enable, flush and bubble controls:
  - load-use stall request from the load-stall detector
  - taken-branch redirect
  - multicycle-multiply issue
- Owns the multiply-occupancy counter, the post-reset start-up state and the optional stall statistics.

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage DLX integer pipeline: merges ID-stage hazard requests into per-stage enables.
// Optional stall statistics counter enabled by defining HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load_stall,
  input  logic                 branch_taken_id,
  input  logic                 mul_issue_id,
  input  logic                 stat_clr,
  output logic                 pc_we,
  output logic                 ifid_we,
  output logic                 ifid_flush,
  output logic                 idex_we,
  output logic                 idex_bubble,
  output logic                 exmem_bubble,
  output logic                 mul_done,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_RUN     = 2'd1,
    S_LSTALL  = 2'd2,
    S_MULWAIT = 2'd3
  } state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);
  localparam bit         MUL_FREEZE = (MUL_LATENCY > 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_mul_cnt;
  logic [3:0] w_mul_cnt_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_INIT;
      r_mul_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_next;
      r_mul_cnt <= w_mul_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_mul_cnt_next = r_mul_cnt;
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    idex_we        = 1'b1;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    exmem_bubble   = 1'b0;
    mul_done       = 1'b0;
    busy           = 1'b1;

    case (r_state)
      S_INIT: begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        idex_bubble  = 1'b1;
        exmem_bubble = 1'b1;
        w_state_next = S_RUN;
      end

      S_RUN, S_LSTALL: begin
        // A load stall is never honoured twice in a row: LSTALL masks it.
        busy         = (r_state != S_RUN);
        w_state_next = S_RUN;
        if (branch_taken_id) begin
          ifid_flush = 1'b1;
        end else if (load_stall && (r_state == S_RUN)) begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_bubble  = 1'b1;
          w_state_next = S_LSTALL;
        end else if (mul_issue_id && MUL_FREEZE) begin
          w_mul_cnt_next = MUL_LOAD;
          w_state_next   = S_MULWAIT;
        end
      end

      S_MULWAIT: begin
        pc_we          = 1'b0;
        ifid_we        = 1'b0;
        idex_we        = 1'b0;
        exmem_bubble   = 1'b1;
        w_mul_cnt_next = r_mul_cnt - 4'd1;
        // Leaving on <=1 also recovers from a corrupted zero count.
        if (r_mul_cnt <= 4'd1) begin
          mul_done       = 1'b1;
          w_mul_cnt_next = 4'd0;
          w_state_next   = S_RUN;
        end
      end

      default: begin
        w_state_next = S_INIT;
      end
    endcase
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic                 w_stall_inc;

  assign w_stall_inc = !pc_we && (r_state != S_INIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (stat_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  logic w_unused_stat_clr;
  assign w_unused_stat_clr = stat_clr;
  assign stall_cycles      = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MUL_LATENCY=4.
// Stall-count expectations follow HAZARD_CTRL_PERF_EN (zero when undefined).
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  logic             clock;
  logic             reset_n;
  logic             load_stall;
  logic             branch_taken_id;
  logic             mul_issue_id;
  logic             stat_clr;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_we;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             mul_done;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;

  // Output vector order: pc_we ifid_we ifid_flush idex_we idex_bubble exmem_bubble mul_done busy
  localparam logic [7:0] V_INIT   = 8'b0000_1101;
  localparam logic [7:0] V_RUN    = 8'b1101_0000;
  localparam logic [7:0] V_LDSTL  = 8'b0001_1000;
  localparam logic [7:0] V_LSTALL = 8'b1101_0001;
  localparam logic [7:0] V_BRANCH = 8'b1111_0000;
  localparam logic [7:0] V_BRLST  = 8'b1111_0001;
  localparam logic [7:0] V_MULW   = 8'b0000_0101;
  localparam logic [7:0] V_MULD   = 8'b0000_0111;

  hazard_ctrl #(
    .MUL_LATENCY(4),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .load_stall     (load_stall),
    .branch_taken_id(branch_taken_id),
    .mul_issue_id   (mul_issue_id),
    .stat_clr       (stat_clr),
    .pc_we          (pc_we),
    .ifid_we        (ifid_we),
    .ifid_flush     (ifid_flush),
    .idex_we        (idex_we),
    .idex_bubble    (idex_bubble),
    .exmem_bubble   (exmem_bubble),
    .mul_done       (mul_done),
    .busy           (busy),
    .stall_cycles   (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp_v);
    logic [7:0] obs;
    obs = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, mul_done, busy};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_cnt(input string tag);
    logic [CNT_W-1:0] exp_c;
`ifdef HAZARD_CTRL_PERF_EN
    exp_c = CNT_W'(exp_stall);
`else
    exp_c = '0;
`endif
    checks++;
    assert (stall_cycles === exp_c) else begin
      errors++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, exp_c);
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    load_stall      = 1'b0;
    branch_taken_id = 1'b0;
    mul_issue_id    = 1'b0;
    stat_clr        = 1'b0;

    // Reset held: INIT outputs regardless of inputs
    tick();
    load_stall = 1'b1; branch_taken_id = 1'b1;
    #1 chk_out("reset_hold", V_INIT);
    chk_cnt("reset_cnt");
    load_stall = 1'b0; branch_taken_id = 1'b0;
    tick();

    // Release: one INIT cycle, then RUN
    reset_n = 1'b1;
    #1 chk_out("init_cycle", V_INIT);
    tick();
    chk_out("run_idle", V_RUN);

    // Load stall held two cycles: second one masked in LSTALL
    load_stall = 1'b1;
    #1 chk_out("ld_stall", V_LDSTL);
    tick(); exp_stall++;
    chk_out("lstall_mask", V_LSTALL);
    tick();
    load_stall = 1'b0;
    #1 chk_out("ld_back_run", V_RUN);
    chk_cnt("cnt_after_ld");

    // Multiply freeze: 3 cycles, done on the third
    mul_issue_id = 1'b1;
    #1 chk_out("mul_issue", V_RUN);
    tick(); mul_issue_id = 1'b0;
    #1 chk_out("mulw1", V_MULW);
    tick(); chk_out("mulw2", V_MULW);
    tick(); chk_out("mulw3_done", V_MULD);
    tick(); exp_stall += 3;
    chk_out("mul_back_run", V_RUN);
    chk_cnt("cnt_after_mul");

    // Branch wins over load stall, state stays RUN
    branch_taken_id = 1'b1; load_stall = 1'b1;
    #1 chk_out("br_over_ld", V_BRANCH);
    tick();
    branch_taken_id = 1'b0; load_stall = 1'b0;
    #1 chk_out("br_stay_run", V_RUN);
    chk_cnt("cnt_after_br");

    // Branch held across MULWAIT: no flush until RUN
    mul_issue_id = 1'b1;
    tick(); mul_issue_id = 1'b0; branch_taken_id = 1'b1;
    #1 chk_out("br_mulw1", V_MULW);
    tick(); chk_out("br_mulw2", V_MULW);
    tick(); chk_out("br_mulw3", V_MULD);
    tick(); exp_stall += 3;
    chk_out("br_resume_flush", V_BRANCH);
    tick(); branch_taken_id = 1'b0;
    #1 chk_out("br_resume_run", V_RUN);
    chk_cnt("cnt_after_brmul");

    // Multiply issued from LSTALL, and branch honoured in LSTALL
    load_stall = 1'b1;
    tick(); exp_stall++;
    load_stall = 1'b0; mul_issue_id = 1'b1;
    #1 chk_out("lstall_mul", V_LSTALL);
    tick(); mul_issue_id = 1'b0;
    #1 chk_out("lstall_to_mulw", V_MULW);
    tick(); tick();
    chk_out("lstall_mul_done", V_MULD);
    tick(); exp_stall += 3;
    load_stall = 1'b1;
    tick(); exp_stall++;
    load_stall = 1'b0; branch_taken_id = 1'b1;
    #1 chk_out("lstall_branch", V_BRLST);
    tick(); branch_taken_id = 1'b0;
    #1 chk_out("lstall_br_run", V_RUN);
    chk_cnt("cnt_before_clr");

    // stat_clr beats a same-cycle stall increment
    stat_clr = 1'b1; load_stall = 1'b1;
    tick(); exp_stall = 0;
    stat_clr = 1'b0; load_stall = 1'b0;
    #1 chk_cnt("cnt_cleared");
    tick();

    // Reset in the second MULWAIT cycle
    mul_issue_id = 1'b1;
    tick(); mul_issue_id = 1'b0;
    #1 chk_out("rst_mulw1", V_MULW);
    tick();
    chk_out("rst_mulw2", V_MULW);
    reset_n = 1'b0;
    #1 chk_out("rst_async_init", V_INIT);
    exp_stall = 0;
    chk_cnt("rst_async_cnt");
    tick(); tick();
    chk_out("rst_held_init", V_INIT);
    reset_n = 1'b1;
    #1 chk_out("rst_rel_init", V_INIT);
    tick();
    chk_out("rst_rel_run", V_RUN);
    tick();
    chk_out("rst_no_done", V_RUN);
    chk_cnt("rst_cnt_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
